// File: rtl/aes_enc_iter.sv
// Purpose : iterative AES-128 encryptor, one round per clock (FIPS-197 byte order, [127:120] = byte 0).
// Latency : 11 edges from the start-accept edge to the edge that raises done; 12-cycle period under continuous start.
// Backpres: none; start is only sampled in IDLE, ignored while busy or in DONE; done is a single-cycle pulse.
//
// Ports: clk, rst_n (async active-low), start, plaintext[127:0], key[127:0]
//        -> busy (ROUND), done (1-cycle pulse), ciphertext[127:0] (registered, held).
// Build option: define AES_ENC_ZEROIZE_EN to clear the state/round-key registers on DONE->IDLE
//               and clear ciphertext when a new start is accepted.

// Single-byte S-box lookup. The table is packed MSB-first, so entry x sits at bit offset (255-x)*8.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // ~a == 255-a, so {~a,3'b000} is the bit offset of entry a
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module subbytes (
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a(a[8*i +: 8]), .y(y[8*i +: 8]));
  end
endmodule

// Byte (row r, column c) lives at [127-8*(4c+r) -: 8]; row r rotates left by r columns.
module shiftrow (
  input  logic [127:0] a,
  output logic [127:0] y
);
  always_comb begin
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[127 - 8*(4*c + r) -: 8] = a[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  end
endmodule

module mixcolumn (
  input  logic [127:0] a,
  output logic [127:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24]; s1 = col[23:16]; s2 = col[15:8]; s3 = col[7:0];
    return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
            xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign y[32*c +: 32] = mix_col(a[32*c +: 32]);
  end
endmodule

// Next AES-128 round key from the current one. rc outside 1..10 yields a zero rcon,
// which the controller never relies on.
module KeyGeneration (
  input  logic [3:0]   rc,
  input  logic [127:0] key_in,
  output logic [127:0] key_out
);
  logic [31:0] w0, w1, w2, w3, rot, sw, t, n0, n1, n2, n3;
  logic [7:0]  rcon;

  assign w0  = key_in[127:96];
  assign w1  = key_in[95:64];
  assign w2  = key_in[63:32];
  assign w3  = key_in[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sw
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sw[8*i +: 8]));
  end

  always_comb begin
    rcon = 8'h00;
    case (rc)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sw ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_out = {n0, n1, n2, n3};
endmodule

module aes_enc_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] st_q, rk_q;
  logic [3:0]   rc_q;
  logic [127:0] sb_out, sr_out, mc_out, kg_out;

  subbytes     u_sb (.a(st_q),   .y(sb_out));
  shiftrow     u_sr (.a(sb_out), .y(sr_out));
  mixcolumn    u_mc (.a(sr_out), .y(mc_out));
  KeyGeneration u_kg (.rc(rc_q), .key_in(rk_q), .key_out(kg_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
      st_q       <= '0;
      rk_q       <= '0;
      rc_q       <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            st_q <= plaintext ^ key;   // initial AddRoundKey
            rk_q <= key;
            rc_q <= 4'd1;
            busy <= 1'b1;
            fsm  <= ROUND;
`ifdef AES_ENC_ZEROIZE_EN
            ciphertext <= '0;
`endif
          end
        end
        ROUND: begin
          if (rc_q == 4'd10) begin
            // final round has no MixColumns
            ciphertext <= sr_out ^ kg_out;
            busy       <= 1'b0;
            done       <= 1'b1;
            fsm        <= DONE;
          end else if (rc_q >= 4'd1 && rc_q <= 4'd9) begin
            st_q <= mc_out ^ kg_out;
            rk_q <= kg_out;
            rc_q <= rc_q + 4'd1;
          end else begin
            // unreachable counter value: abandon the block rather than emit garbage
            busy <= 1'b0;
            fsm  <= IDLE;
          end
        end
        DONE: begin
          done <= 1'b0;
          fsm  <= IDLE;
`ifdef AES_ENC_ZEROIZE_EN
          st_q <= '0;
          rk_q <= '0;
`endif
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          fsm  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_enc_iter.sv
module tb_aes_enc_iter;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [127:0] plaintext, key;
  logic         busy, done;
  logic [127:0] ciphertext;

  int checks = 0, errors = 0, done_cnt = 0, cyc = 0;
  logic [127:0] sb[$];
  int           done_times[$];
  logic         prev_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  aes_enc_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext), .key(key),
    .busy(busy), .done(done), .ciphertext(ciphertext)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: every done pulse pops one expected ciphertext.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      done_times.push_back(cyc);
      chk("done_one_cycle", {127'b0, prev_done}, 128'd0);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_done: observed done with empty scoreboard, expected no done");
      end
      if (sb.size() > 0) chk("ciphertext", ciphertext, sb.pop_front());
    end
    prev_done = done;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One encryption from an idle DUT; checks latency (edges counted including the accept edge) and busy width.
  task automatic run_one(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp,
                         input string tag);
    int edges, bcyc;
    @(negedge clk);
    start = 1'b1; plaintext = pt; key = k;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    bcyc  = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) bcyc++;
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, 128'(edges), 128'd11);
    chk({tag, "_busy_cycles"}, 128'(bcyc), 128'd10);
    chk({tag, "_busy_at_done"}, {127'b0, busy}, 128'd0);
    @(negedge clk);
    chk({tag, "_done_low_after"}, {127'b0, done}, 128'd0);
  endtask

  initial begin
    int base, waited;
    logic [127:0] zexp;
    rst_n = 1'b0; start = 1'b0; plaintext = '0; key = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_done", {127'b0, done}, 128'd0);
    chk("reset_ct", ciphertext, 128'd0);
    rst_n = 1'b1;

    run_one(B_PT, B_KEY, B_CT, "appb");
    run_one(C1_PT, C1_KEY, C1_CT, "c1");

    // Second start: zeroize visibility, ignored start while busy, inputs changing mid-block.
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; plaintext = C1_PT; key = C1_KEY;
    sb.push_back(C1_CT);
    @(negedge clk);
`ifdef AES_ENC_ZEROIZE_EN
    zexp = '0;
`else
    zexp = C1_CT;
`endif
    chk("zeroize_ct_after_start", ciphertext, zexp);
    plaintext = B_PT; key = B_KEY;   // start stays high for this cycle: must be ignored
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    plaintext = ~C1_PT; key = ~C1_KEY;
    repeat (25) @(negedge clk);
    chk("busy_ignore_done_count", 128'(done_cnt - base), 128'd1);
    chk("busy_ignore_sb_empty", 128'(sb.size()), 128'd0);

    // Reset mid-encryption.
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; plaintext = C1_PT; key = C1_KEY;
    sb.push_back(C1_CT);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {127'b0, busy}, 128'd0);
    chk("midreset_done", {127'b0, done}, 128'd0);
    chk("midreset_ct", ciphertext, 128'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midreset_no_done", 128'(done_cnt - base), 128'd0);
    run_one(C1_PT, C1_KEY, C1_CT, "c1_after_reset");

    // Start asserted during DONE must be ignored.
    @(negedge clk);
    start = 1'b1; plaintext = C1_PT; key = C1_KEY;
    sb.push_back(C1_CT);
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (done !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("done_start_reached_done", {127'b0, done}, 128'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = done_cnt;
    repeat (2) @(negedge clk);
    chk("done_start_not_busy", {127'b0, busy}, 128'd0);
    repeat (13) @(negedge clk);
    chk("done_start_no_done", 128'(done_cnt - base), 128'd0);

    // start held high: back-to-back blocks every 12 cycles.
    done_times.delete();
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; plaintext = C1_PT; key = C1_KEY;
    repeat (3) sb.push_back(C1_CT);
    repeat (30) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_done_count", 128'(done_cnt - base), 128'd3);
    if (done_times.size() == 3) begin
      chk("held_period_1", 128'(done_times[1] - done_times[0]), 128'd12);
      chk("held_period_2", 128'(done_times[2] - done_times[1]), 128'd12);
    end
    chk("held_sb_empty", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_enc_iter.md
AES_ENC_ITER -- requirements
Module: aes_enc_iter

Interface
REQ-001 clk  input  1  single clock; all state changes on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 start  input  1  request to encrypt; sampled only in IDLE.
REQ-004 plaintext  input  128  block to encrypt; captured at the accepted start edge.
REQ-005 key  input  128  AES-128 cipher key; captured at the accepted start edge.
REQ-006 busy  output  1  high while rounds are in progress.
REQ-007 done  output  1  one-cycle pulse when ciphertext is valid.
REQ-008 ciphertext  output  128  registered result; held until the next completion.
REQ-009 Byte order follows FIPS-197: bits [127:120] = byte 0 (row 0, column 0), column-major.

Function
REQ-010 The block SHALL be an iterative AES-128 encryptor with one round per clock, built from the existing KeyGeneration, subbytes, shiftrow and mixcolumn blocks.
REQ-011 It SHALL have three states: IDLE, ROUND and DONE.
REQ-012 IDLE with start=1 SHALL trigger the following at the next edge:
- state register <= plaintext^key;
- round-key register <= key;
- round counter rc <= 1;
- go to ROUND.
REQ-013 In ROUND with rc=1..9, each edge SHALL do:
- state <= mixcolumn(shiftrow(subbytes(state))) ^ KeyGeneration(rc, roundkey);
- roundkey <= KeyGeneration(rc, roundkey);
- rc <= rc+1.
REQ-014 In ROUND with rc=10, the edge SHALL do:
- ciphertext <= shiftrow(subbytes(state)) ^ KeyGeneration(10, roundkey), with no mixcolumn;
- go to DONE.
REQ-015 rc SHALL be 4 bits and SHALL never leave 1..10 while in ROUND; rc values 0 and 11..15 SHALL never be presented to KeyGeneration as valid.
REQ-016 Latency SHALL be exactly 11 edges from the start-accept edge to the edge at which done rises; done SHALL be high for exactly one cycle.
REQ-017 busy SHALL be 1 in ROUND and 0 in IDLE and DONE.
REQ-018 DONE SHALL return to IDLE unconditionally on the next edge; start asserted during DONE SHALL be ignored.
REQ-019 start asserted while busy=1 SHALL be ignored, and plaintext/key changes while busy SHALL NOT affect the result.
REQ-020 start held high continuously SHALL start a new block on every IDLE cycle, giving a 12-cycle period per block.
REQ-021 ciphertext SHALL change only at the rc=10 edge, or at reset, or as defined in REQ-026.

Reset
REQ-022 While rst_n=0, the block SHALL immediately force:
- state to IDLE;
- busy=0, done=0;
- ciphertext=0;
- state register, round-key register and rc to 0.
REQ-023 Reset asserted mid-encryption SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL run a full 11-edge encryption.
REQ-024 The first edge with rst_n=1 SHALL behave as a normal IDLE edge.

Configuration
REQ-025 Macro AES_ENC_ZEROIZE_EN.
REQ-026 With AES_ENC_ZEROIZE_EN defined:
- state and round-key registers SHALL be cleared to 0 at the DONE->IDLE edge;
- ciphertext SHALL be cleared to 0 at each start-accept edge.
REQ-027 Without AES_ENC_ZEROIZE_EN:
- internal registers SHALL retain their last values;
- ciphertext SHALL hold until overwritten by the next completion.

Verification
REQ-028 FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff, one-cycle start -> done after exactly 11 edges with ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-029 FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, plaintext=3243f6a8885a308d313198a2e0370734 -> ciphertext=3925841d02dc09fbdc118597196a0b32; busy high for 10 cycles.
REQ-030 Start C.1 vector, then pulse start with the App. B vector and change plaintext/key at edge 5 -> one done only, with result 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-031 Start C.1 vector, drop rst_n at edge 6 -> immediately busy=0, done=0, ciphertext=0; no done afterwards; a restart with the same vector yields the correct result 11 edges later.
REQ-032 start held high with C.1 vector for 30 cycles -> done pulses 12 cycles apart, each with 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Zeroize check:
- with AES_ENC_ZEROIZE_EN, ciphertext reads 0 in the cycle after a second start is accepted;
- without AES_ENC_ZEROIZE_EN, it still reads 69c4e0d86a7b0430d8cdb78070b4c55a at that point.
